mul16_issue_ctrl: RTL and testbench
===================================

Name: mul16_issue_ctrl

Overview:
- Initiator-side controller for the progressive signed multiplier.
- Accepts one multiply request at a time over a valid/ready interface.
- Formats operands for the requested precision, pulses the multiplier's valid input once, waits for the matching result valid, and returns the result normalized to Q1.30 over a valid/ready response interface.
- Has a timeout and a drain interval so stale valids from a previous transaction are never captured.

Parameters:
TIMEOUT_CYCLES, 16, number of WAIT cycles before a timeout error is returned
DRAIN_CYCLES, 8, idle cycles with mul_valid_in low after each issued transaction
CNT_W, 5, width of the wait/drain counter; must hold max(TIMEOUT_CYCLES, DRAIN_CYCLES)

Ports:
clk  input  1  single clock; all logic on its rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  1  request valid
req_ready  output  1  high only in IDLE
req_a  input  16  signed Q0.15 operand A
req_b  input  16  signed Q0.15 operand B
req_prec  input  2  precision: 0=Q1.6, 1=Q1.14, 2=Q1.30, 3=reserved
rsp_valid  output  1  response valid
rsp_ready  input  1  response accept
rsp_data  output  32  signed Q1.30 result
rsp_prec  output  2  precision of the returned result
rsp_err  output  1  reserved precision or timeout
mul_a  output  16  operand A to the multiplier
mul_b  output  16  operand B to the multiplier
mul_valid_in  output  1  one-cycle issue pulse to the multiplier
mul_q1_6  input  8  multiplier Q1.6 result
mul_q1_6_valid  input  1  valid for mul_q1_6
mul_q1_14  input  16  multiplier Q1.14 result
mul_q1_14_valid  input  1  valid for mul_q1_14
mul_q1_30  input  32  multiplier Q1.30 result
mul_q1_30_valid  input  1  valid for mul_q1_30
busy  output  1  high whenever state is not IDLE

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- While rst_n=0 at a clk edge, the state goes to IDLE and counters clear. These outputs are 0: rsp_valid, rsp_data, rsp_prec, rsp_err, mul_a, mul_b, mul_valid_in. req_ready=1 after reset.
- Reset mid-operation aborts the transaction and discards any pending response. Multiplier valids arriving afterwards are ignored, because IDLE never captures.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE: req_ready=1. On req_valid&&req_ready, latch the precision.
  - Precision 3: go directly to RESP with rsp_err=1 and rsp_data=0. Nothing is issued.
  - Otherwise go to ISSUE.
  - Operand formatting uses sign-extended top bits:
    - prec0: mul_a={{12{a[15]}},a[15:12]}
    - prec1: mul_a={{8{a[15]}},a[15:8]}
    - prec2: mul_a=a
    - mul_b is formatted identically.
- ISSUE: mul_valid_in=1 for exactly this cycle, then go to WAIT with wait_cnt=1.
- WAIT: select the valid/data pair for the latched precision.
  - If the selected valid is 1, capture and normalize the data, then go to RESP with rsp_err=0:
    - prec0: {q1_6, 24'b0}
    - prec1: {q1_14, 16'b0}
    - prec2: q1_30
  - Otherwise, if wait_cnt==TIMEOUT_CYCLES, go to RESP with rsp_err=1 and rsp_data=0.
  - Otherwise increment wait_cnt.
  - If capture and timeout fall in the same cycle, capture wins.
  - Non-selected valids are ignored.
- RESP: rsp_valid=1. rsp_data, rsp_prec and rsp_err hold stable until rsp_valid&&rsp_ready.
  - On handshake: go to DRAIN if an issue occurred (including timeout), or to IDLE for a reserved-precision error.
  - rsp_valid drops the cycle after the handshake.
- DRAIN: mul_valid_in=0 for DRAIN_CYCLES cycles, then go to IDLE. req_ready=0 throughout.
- Latency, successful capture: request accepted at edge 0, mul_valid_in high in cycle 1, WAIT from cycle 2. rsp_valid asserts the cycle after the capturing WAIT cycle.
- Throughput: at most one outstanding multiplier transaction, ever.
- Arithmetic: pure bit placement; no rounding or saturation. Sign is preserved by the MSB alignment.

Test Plan:
1. prec2, a=0x4000, b=0x4000; multiplier model returns 0x10000000 -> mul_a=mul_b=0x4000, one-cycle mul_valid_in pulse, rsp_data=0x10000000, rsp_prec=2, rsp_err=0.
2. prec0, a=0x4000, b=0xC000 -> mul_a=0x0004, mul_b=0xFFFC; model q1_6=0xF0 -> rsp_data=0xF0000000, rsp_err=0.
3. prec1, a=b=0x7FFF -> mul_a=mul_b=0x007F; model q1_14=0x3F01 -> rsp_data=0x3F010000.
4. prec3, any operands -> rsp_valid the cycle after acceptance, rsp_err=1, rsp_data=0, mul_valid_in never asserted, req_ready=1 the cycle after the handshake.
5. prec2 with model never asserting q1_30_valid, while q1_6_valid is held high -> rsp_err=1, rsp_data=0 after 16 WAIT cycles; then 8 DRAIN cycles before req_ready=1.
6. rsp_ready held low 5 cycles during RESP -> response fields stable, busy=1. Then in a separate transaction, assert rst_n=0 mid-WAIT -> all outputs 0 next edge, req_ready=1 after release, and a late model valid produces no response.

Source files
------------

// File: rtl/mul16_issue_ctrl.sv
// Initiator-side controller for the progressive signed multiplier: one request in flight,
// operand formatting per precision, result capture with timeout, and a post-issue drain.
module mul16_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int DRAIN_CYCLES   = 8,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [1:0]  req_prec,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_prec,
  output logic        rsp_err,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  output logic        mul_valid_in,
  input  logic [7:0]  mul_q1_6,
  input  logic        mul_q1_6_valid,
  input  logic [15:0] mul_q1_14,
  input  logic        mul_q1_14_valid,
  input  logic [31:0] mul_q1_30,
  input  logic        mul_q1_30_valid,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} state_t;

  localparam logic [1:0] PREC_RSVD = 2'd3;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       prec_q, prec_d;
  logic             req_ready_d, busy_d, rsp_valid_d, rsp_err_d, mul_valid_in_d;
  logic [31:0]      rsp_data_d;
  logic [1:0]       rsp_prec_d;
  logic [15:0]      mul_a_d, mul_b_d;
  logic             sel_vld;
  logic [31:0]      sel_data;

  // Narrow precisions take the operand's top bits, sign-extended to 16.
  function automatic logic [15:0] fmt_op(input logic [15:0] x, input logic [1:0] p);
    case (p)
      2'd0:    fmt_op = {{12{x[15]}}, x[15:12]};
      2'd1:    fmt_op = {{8{x[15]}}, x[15:8]};
      default: fmt_op = x;
    endcase
  endfunction

  // Result is MSB-aligned into Q1.30, so the sign lands in bit 31 for every precision.
  always_comb begin
    sel_vld  = 1'b0;
    sel_data = '0;
    case (prec_q)
      2'd0: begin sel_vld = mul_q1_6_valid;  sel_data = {mul_q1_6, 24'b0};  end
      2'd1: begin sel_vld = mul_q1_14_valid; sel_data = {mul_q1_14, 16'b0}; end
      2'd2: begin sel_vld = mul_q1_30_valid; sel_data = mul_q1_30;          end
      default: ;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    prec_d         = prec_q;
    rsp_valid_d    = rsp_valid;
    rsp_data_d     = rsp_data;
    rsp_prec_d     = rsp_prec;
    rsp_err_d      = rsp_err;
    mul_a_d        = mul_a;
    mul_b_d        = mul_b;
    mul_valid_in_d = 1'b0;
    case (state_q)
      S_IDLE: if (req_valid && req_ready) begin
        prec_d = req_prec;
        if (req_prec == PREC_RSVD) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
          rsp_prec_d  = req_prec;
        end else begin
          state_d        = S_ISSUE;
          mul_a_d        = fmt_op(req_a, req_prec);
          mul_b_d        = fmt_op(req_b, req_prec);
          mul_valid_in_d = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = CNT_W'(1);
      end
      S_WAIT: begin
        if (sel_vld) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = sel_data;
          rsp_err_d   = 1'b0;
          rsp_prec_d  = prec_q;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_prec_d  = prec_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: if (rsp_valid && rsp_ready) begin
        rsp_valid_d = 1'b0;
        // Anything that reached the multiplier must drain so its stale valids die out.
        if (prec_q == PREC_RSVD) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
          cnt_d   = CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == CNT_W'(DRAIN_CYCLES)) state_d = S_IDLE;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      prec_q       <= '0;
      req_ready    <= 1'b1;
      busy         <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_prec     <= '0;
      rsp_err      <= 1'b0;
      mul_a        <= '0;
      mul_b        <= '0;
      mul_valid_in <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prec_q       <= prec_d;
      req_ready    <= req_ready_d;
      busy         <= busy_d;
      rsp_valid    <= rsp_valid_d;
      rsp_data     <= rsp_data_d;
      rsp_prec     <= rsp_prec_d;
      rsp_err      <= rsp_err_d;
      mul_a        <= mul_a_d;
      mul_b        <= mul_b_d;
      mul_valid_in <= mul_valid_in_d;
    end
  end

endmodule

// File: tb/tb_mul16_issue_ctrl.sv
// Directed bench for mul16_issue_ctrl: the test drives the multiplier result ports by hand.
module tb_mul16_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [15:0] req_a, req_b, mul_a, mul_b, mul_q1_14;
  logic [1:0]  req_prec, rsp_prec;
  logic [31:0] rsp_data, mul_q1_30;
  logic        mul_valid_in, mul_q1_6_valid, mul_q1_14_valid, mul_q1_30_valid, busy;
  logic [7:0]  mul_q1_6;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  mul16_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_prec(req_prec), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_prec(rsp_prec), .rsp_err(rsp_err),
    .mul_a(mul_a), .mul_b(mul_b), .mul_valid_in(mul_valid_in),
    .mul_q1_6(mul_q1_6), .mul_q1_6_valid(mul_q1_6_valid),
    .mul_q1_14(mul_q1_14), .mul_q1_14_valid(mul_q1_14_valid),
    .mul_q1_30(mul_q1_30), .mul_q1_30_valid(mul_q1_30_valid), .busy(busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a request and let the next edge accept it.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [1:0] p);
    req_valid = 1'b1; req_a = a; req_b = b; req_prec = p;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (!req_ready && k < 40) begin tick(); k++; end
    n_chk++;
    if (!req_ready) begin n_fail++; $display("FAIL %s_idle_timeout: req_ready=%b want 1", name, req_ready); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(); tick();
    n_chk++;
    if ({req_ready, busy, rsp_valid, rsp_err, mul_valid_in} !== 5'b10000 || rsp_data !== 32'h0 ||
        rsp_prec !== 2'd0 || mul_a !== 16'h0 || mul_b !== 16'h0) begin
      n_fail++;
      $display("FAIL reset: rdy=%b busy=%b rv=%b err=%b mvi=%b data=%h prec=%0d a=%h b=%h", req_ready,
               busy, rsp_valid, rsp_err, mul_valid_in, rsp_data, rsp_prec, mul_a, mul_b);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_prec2;
    send(16'h4000, 16'h4000, 2'd2);
    n_chk++;
    if (mul_valid_in !== 1'b1 || mul_a !== 16'h4000 || mul_b !== 16'h4000 || req_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL p2_issue: mvi=%b a=%h b=%h rdy=%b busy=%b want 1 4000 4000 0 1", mul_valid_in, mul_a, mul_b, req_ready, busy);
    end
    tick();
    n_chk++;
    if (mul_valid_in !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL p2_pulse: mvi=%b rv=%b want 0 0", mul_valid_in, rsp_valid);
    end
    mul_q1_30 = 32'h1000_0000; mul_q1_30_valid = 1'b1;
    tick();
    mul_q1_30_valid = 1'b0;
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h1000_0000 || rsp_prec !== 2'd2 || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL p2_rsp: rv=%b data=%h prec=%0d err=%b want 1 10000000 2 0", rsp_valid, rsp_data, rsp_prec, rsp_err);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_chk++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++; $display("FAIL p2_hs: rv=%b rdy=%b want 0 0", rsp_valid, req_ready);
    end
    wait_idle("p2");
  endtask

  task automatic test_prec0;
    send(16'h4000, 16'hC000, 2'd0);
    n_chk++;
    if (mul_a !== 16'h0004 || mul_b !== 16'hFFFC || mul_valid_in !== 1'b1) begin
      n_fail++; $display("FAIL p0_fmt: a=%h b=%h mvi=%b want 0004 fffc 1", mul_a, mul_b, mul_valid_in);
    end
    tick();
    mul_q1_6 = 8'hF0; mul_q1_6_valid = 1'b1;
    tick();
    mul_q1_6_valid = 1'b0;
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'hF000_0000 || rsp_prec !== 2'd0 || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL p0_rsp: rv=%b data=%h prec=%0d err=%b want 1 f0000000 0 0", rsp_valid, rsp_data, rsp_prec, rsp_err);
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    wait_idle("p0");
  endtask

  task automatic test_prec1;
    send(16'h7FFF, 16'h7FFF, 2'd1);
    n_chk++;
    if (mul_a !== 16'h007F || mul_b !== 16'h007F) begin
      n_fail++; $display("FAIL p1_fmt: a=%h b=%h want 007f 007f", mul_a, mul_b);
    end
    tick(); tick();
    mul_q1_14 = 16'h3F01; mul_q1_14_valid = 1'b1;
    tick();
    mul_q1_14_valid = 1'b0;
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h3F01_0000 || rsp_prec !== 2'd1 || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL p1_rsp: rv=%b data=%h prec=%0d err=%b want 1 3f010000 1 0", rsp_valid, rsp_data, rsp_prec, rsp_err);
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    wait_idle("p1");
  endtask

  task automatic test_reserved;
    send(16'h1234, 16'h5678, 2'd3);
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'h0 || mul_valid_in !== 1'b0) begin
      n_fail++; $display("FAIL p3_rsp: rv=%b err=%b data=%h mvi=%b want 1 1 0 0", rsp_valid, rsp_err, rsp_data, mul_valid_in);
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    n_chk++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mul_valid_in !== 1'b0) begin
      n_fail++; $display("FAIL p3_hs: rv=%b rdy=%b mvi=%b want 0 1 0", rsp_valid, req_ready, mul_valid_in);
    end
  endtask

  task automatic test_timeout;
    mul_q1_6 = 8'h55; mul_q1_6_valid = 1'b1;
    send(16'h4000, 16'h4000, 2'd2);
    tick();
    repeat (15) tick();
    n_chk++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL to_early: rv=%b want 0 after 15 WAIT cycles", rsp_valid);
    end
    tick();
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'h0 || rsp_prec !== 2'd2) begin
      n_fail++; $display("FAIL to_rsp: rv=%b err=%b data=%h prec=%0d want 1 1 0 2", rsp_valid, rsp_err, rsp_data, rsp_prec);
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    repeat (7) tick();
    n_chk++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL to_drain: rdy=%b busy=%b want 0 1 after 7 drain cycles", req_ready, busy);
    end
    tick();
    mul_q1_6_valid = 1'b0;
    n_chk++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || mul_valid_in !== 1'b0) begin
      n_fail++; $display("FAIL to_idle: rdy=%b busy=%b mvi=%b want 1 0 0", req_ready, busy, mul_valid_in);
    end
  endtask

  task automatic test_capture_at_timeout;
    send(16'h2000, 16'h2000, 2'd2);
    tick();
    repeat (15) tick();
    mul_q1_30 = 32'h0400_0000; mul_q1_30_valid = 1'b1;
    tick();
    mul_q1_30_valid = 1'b0;
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 32'h0400_0000) begin
      n_fail++; $display("FAIL cap_vs_to: rv=%b err=%b data=%h want 1 0 04000000", rsp_valid, rsp_err, rsp_data);
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    wait_idle("cap");
  endtask

  task automatic test_backpressure_and_reset;
    send(16'hC000, 16'h4000, 2'd2);
    tick();
    mul_q1_30 = 32'hF000_0000; mul_q1_30_valid = 1'b1;
    tick();
    mul_q1_30_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'hF000_0000 || rsp_prec !== 2'd2 || rsp_err !== 1'b0 || busy !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold%0d: rv=%b data=%h prec=%0d err=%b busy=%b", i, rsp_valid, rsp_data, rsp_prec, rsp_err, busy);
      end
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    wait_idle("bp");
    send(16'h7FFF, 16'h7FFF, 2'd1);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    n_chk++;
    if ({rsp_valid, rsp_err, mul_valid_in, busy} !== 4'b0000 || rsp_data !== 32'h0 || rsp_prec !== 2'd0 ||
        mul_a !== 16'h0 || mul_b !== 16'h0) begin
      n_fail++; $display("FAIL rst_mid: rv=%b err=%b mvi=%b busy=%b data=%h prec=%0d a=%h b=%h", rsp_valid, rsp_err,
                         mul_valid_in, busy, rsp_data, rsp_prec, mul_a, mul_b);
    end
    rst_n = 1'b1;
    mul_q1_14 = 16'h3F01; mul_q1_14_valid = 1'b1;
    tick();
    n_chk++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_rdy: rdy=%b want 1", req_ready);
    end
    repeat (3) tick();
    mul_q1_14_valid = 1'b0;
    n_chk++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_late: rv=%b busy=%b rdy=%b want 0 0 1", rsp_valid, busy, req_ready);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_prec = '0; rsp_ready = 1'b0;
    mul_q1_6 = '0; mul_q1_6_valid = 1'b0; mul_q1_14 = '0; mul_q1_14_valid = 1'b0;
    mul_q1_30 = '0; mul_q1_30_valid = 1'b0;
    #1;
    test_reset();
    test_prec2();
    test_prec0();
    test_prec1();
    test_reserved();
    test_timeout();
    test_capture_at_timeout();
    test_backpressure_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
